dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001: The block SHALL have parameter DATA_WIDTH, default 32, the data bus width.
REQ-002: The block SHALL have parameter ADDR_WIDTH, default 32, the byte address width.
REQ-003: The block SHALL have one clock and an asynchronous active-low reset, with the following ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- s_req  input  1  scalar access request (single beat)
- s_we  input  1  scalar write (1) / read (0)
- s_addr  input  ADDR_WIDTH  scalar byte address
- s_wdata  input  DATA_WIDTH  scalar write data
- s_gnt  output  1  scalar beat issued this cycle
- s_rvalid  output  1  scalar read data valid
- s_rdata  output  DATA_WIDTH  scalar read data
- v_req  input  1  vector burst request
- v_we  input  1  vector burst write / read
- v_addr  input  ADDR_WIDTH  vector burst base byte address
- v_len  input  4  beats minus one (1..16 beats)
- v_wdata  input  DATA_WIDTH  vector write data for the current beat
- v_gnt  output  1  vector beat issued this cycle
- v_done  output  1  last beat of the burst issued this cycle
- v_rvalid  output  1  vector read data valid
- v_rdata  output  DATA_WIDTH  vector read data
- mem_wr_en  output  1  data memory write enable
- mem_rd_en  output  1  data memory read enable
- mem_addr  output  ADDR_WIDTH  data memory address
- mem_wdata  output  DATA_WIDTH  data memory write data
- mem_rdata  input  DATA_WIDTH  data memory combinational read data
- busy  output  1  vector burst in progress (state VEC)

Function
REQ-004: The FSM SHALL have two states, IDLE and VEC, and SHALL track a last_grant flag (S or V).
REQ-005: In IDLE with only s_req set, the block SHALL issue one scalar beat in the same cycle: s_gnt=1, mem_* driven from the s_* inputs, last_grant<=S.
REQ-006: In IDLE with only v_req set, the block SHALL issue beat 0 in the same cycle: v_gnt=1, mem_addr=v_addr, last_grant<=V, and it SHALL latch v_addr, v_we and v_len.
REQ-007: In IDLE with both requests set, the block SHALL grant the requester opposite to last_grant.
REQ-008: After beat 0, if v_len>0 the FSM SHALL enter VEC; if v_len==0 it SHALL assert v_done in the same cycle and remain in IDLE.
REQ-009: In VEC, the block SHALL issue one beat per cycle with mem_addr=latched_addr+4*beat_cnt (modulo 2^ADDR_WIDTH), mem_wdata=v_wdata and v_gnt=1.
REQ-010: The block SHALL assert v_done on the beat where beat_cnt==latched_len, then return to IDLE on the next edge.
REQ-011: In VEC, s_req SHALL be stalled (s_gnt=0); the worst-case scalar wait SHALL be 16 cycles.
REQ-012: Read data SHALL be registered: s_rvalid/v_rvalid SHALL assert exactly one cycle after the issuing beat of a read, with mem_rdata captured at that beat.
REQ-013: mem_rd_en and mem_wr_en SHALL be mutually exclusive, and both SHALL be 0 on any cycle with no grant.
REQ-014: Changes to v_req, v_addr, v_len or v_we during VEC SHALL be ignored; dropping v_req during VEC SHALL NOT abort the burst.
REQ-015: Read data outputs SHALL hold their last value when the corresponding rvalid is 0.

Reset
REQ-016: On rst=0, the block SHALL asynchronously set state=IDLE, beat_cnt=0 and last_grant=V (so the scalar requester wins the first conflict).
REQ-017: During reset, s_rvalid, v_rvalid, s_rdata, v_rdata and busy SHALL be 0, and s_gnt, v_gnt, v_done and mem enables SHALL be forced to 0.
REQ-018: Reset asserted mid-burst SHALL discard the remaining beats without asserting v_done.

Configuration
REQ-019: When macro DMEM_ARB_PERF_CNT_EN is defined, the block SHALL add outputs s_stall_cnt[15:0] and v_stall_cnt[15:0], counting cycles with req=1 and gnt=0, saturating at 0xFFFF and cleared by reset.
REQ-020: When DMEM_ARB_PERF_CNT_EN is undefined, the counter outputs and counter logic SHALL be absent.

Verification
REQ-021: s_req=1, s_we=0, s_addr=0x100, mem_rdata=0xDEADBEEF -> s_gnt=1 same cycle; next cycle s_rvalid=1, s_rdata=0xDEADBEEF.
REQ-022: v_req=1, v_we=1, v_addr=0x200, v_len=3 -> mem_wr_en for 4 consecutive cycles at 0x200/0x204/0x208/0x20C; v_done on the 4th; busy for cycles 2-4.
REQ-023: s_req and v_req both asserted after reset -> scalar granted first, vector burst starts the next cycle; repeating the conflict -> vector wins.
REQ-024: v_addr=0xFFFFFFFC, v_len=1 -> beats at 0xFFFFFFFC then 0x00000000.
REQ-025: rst=0 asserted at beat 2 of a 16-beat read -> outputs zero immediately, no v_done; after release, s_req is granted at once.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: one single-beat scalar requester and one bursting
// vector requester share a data memory port. Bursts are 1..16 word beats.
// Optional stall counters are built when DMEM_ARB_PERF_CNT_EN is defined.
module dmem_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_req,
    input  logic                  s_we,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    output logic                  s_gnt,
    output logic                  s_rvalid,
    output logic [DATA_WIDTH-1:0] s_rdata,
    input  logic                  v_req,
    input  logic                  v_we,
    input  logic [ADDR_WIDTH-1:0] v_addr,
    input  logic [3:0]            v_len,
    input  logic [DATA_WIDTH-1:0] v_wdata,
    output logic                  v_gnt,
    output logic                  v_done,
    output logic                  v_rvalid,
    output logic [DATA_WIDTH-1:0] v_rdata,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
`ifdef DMEM_ARB_PERF_CNT_EN
    ,
    output logic [15:0]           s_stall_cnt,
    output logic [15:0]           v_stall_cnt
`endif
);

    typedef enum logic [0:0] {StIdle, StVec} state_e;

    localparam logic GrantS = 1'b0;
    localparam logic GrantV = 1'b1;

    state_e                state_q, state_d;
    logic [3:0]            beat_cnt_q, beat_cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
    logic                  lat_we_q, lat_we_d;
    logic [3:0]            lat_len_q, lat_len_d;
    logic                  s_rvalid_q, s_rvalid_d;
    logic                  v_rvalid_q, v_rvalid_d;
    logic [DATA_WIDTH-1:0] s_rdata_q, s_rdata_d;
    logic [DATA_WIDTH-1:0] v_rdata_q, v_rdata_d;

    logic                  gnt_s, gnt_v, done_v, beat_we;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [DATA_WIDTH-1:0] beat_wdata;
    logic [ADDR_WIDTH-1:0] beat_offset;

    // Word offset of the current burst beat; wraps modulo 2^ADDR_WIDTH on add.
    assign beat_offset = {{(ADDR_WIDTH-6){1'b0}}, beat_cnt_q, 2'b00};

    // Arbitration, burst sequencing and next-state for control registers.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        last_grant_d = last_grant_q;
        lat_addr_d   = lat_addr_q;
        lat_we_d     = lat_we_q;
        lat_len_d    = lat_len_q;
        gnt_s        = 1'b0;
        gnt_v        = 1'b0;
        done_v       = 1'b0;
        beat_we      = 1'b0;
        beat_addr    = '0;
        beat_wdata   = '0;
        unique case (state_q)
            StIdle: begin
                // On conflict the requester not served last time wins.
                if (s_req && (!v_req || last_grant_q == GrantV)) begin
                    gnt_s        = 1'b1;
                    beat_we      = s_we;
                    beat_addr    = s_addr;
                    beat_wdata   = s_wdata;
                    last_grant_d = GrantS;
                end else if (v_req) begin
                    gnt_v        = 1'b1;
                    beat_we      = v_we;
                    beat_addr    = v_addr;
                    beat_wdata   = v_wdata;
                    last_grant_d = GrantV;
                    lat_addr_d   = v_addr;
                    lat_we_d     = v_we;
                    lat_len_d    = v_len;
                    if (v_len == 4'd0) begin
                        done_v = 1'b1;
                    end else begin
                        state_d    = StVec;
                        beat_cnt_d = 4'd1;
                    end
                end
            end
            StVec: begin
                // Burst runs from latched parameters; live v_* controls are ignored.
                gnt_v      = 1'b1;
                beat_we    = lat_we_q;
                beat_addr  = lat_addr_q + beat_offset;
                beat_wdata = v_wdata;
                if (beat_cnt_q == lat_len_q) begin
                    done_v     = 1'b1;
                    state_d    = StIdle;
                    beat_cnt_d = 4'd0;
                end else begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Read-return next state: capture memory data on the issuing beat, else hold.
    always_comb begin
        s_rvalid_d = gnt_s && !beat_we;
        v_rvalid_d = gnt_v && !beat_we;
        s_rdata_d  = s_rvalid_d ? mem_rdata : s_rdata_q;
        v_rdata_d  = v_rvalid_d ? mem_rdata : v_rdata_q;
    end

    // State and data registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            beat_cnt_q   <= 4'd0;
            last_grant_q <= GrantV;
            lat_addr_q   <= '0;
            lat_we_q     <= 1'b0;
            lat_len_q    <= 4'd0;
            s_rvalid_q   <= 1'b0;
            v_rvalid_q   <= 1'b0;
            s_rdata_q    <= '0;
            v_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            last_grant_q <= last_grant_d;
            lat_addr_q   <= lat_addr_d;
            lat_we_q     <= lat_we_d;
            lat_len_q    <= lat_len_d;
            s_rvalid_q   <= s_rvalid_d;
            v_rvalid_q   <= v_rvalid_d;
            s_rdata_q    <= s_rdata_d;
            v_rdata_q    <= v_rdata_d;
        end
    end

    // Grants and enables are combinational; reset gates them off immediately.
    always_comb begin
        s_gnt     = gnt_s & rst;
        v_gnt     = gnt_v & rst;
        v_done    = done_v & rst;
        mem_wr_en = (gnt_s | gnt_v) & beat_we & rst;
        mem_rd_en = (gnt_s | gnt_v) & ~beat_we & rst;
        mem_addr  = beat_addr;
        mem_wdata = beat_wdata;
        s_rvalid  = s_rvalid_q;
        v_rvalid  = v_rvalid_q;
        s_rdata   = s_rdata_q;
        v_rdata   = v_rdata_q;
        busy      = (state_q == StVec);
    end

`ifdef DMEM_ARB_PERF_CNT_EN
    logic [15:0] s_stall_q, s_stall_d;
    logic [15:0] v_stall_q, v_stall_d;

    // Saturating counts of cycles a requester waited without a grant.
    always_comb begin
        s_stall_d = s_stall_q;
        v_stall_d = v_stall_q;
        if (s_req && !gnt_s && s_stall_q != 16'hFFFF) s_stall_d = s_stall_q + 16'd1;
        if (v_req && !gnt_v && v_stall_q != 16'hFFFF) v_stall_d = v_stall_q + 16'd1;
    end

    // Stall counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_stall_q <= 16'd0;
            v_stall_q <= 16'd0;
        end else begin
            s_stall_q <= s_stall_d;
            v_stall_q <= v_stall_d;
        end
    end

    assign s_stall_cnt = s_stall_q;
    assign v_stall_cnt = v_stall_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: inputs change on the falling edge and
// outputs are checked 1 time unit later, well away from the rising edge.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_req, s_we, v_req, v_we;
    logic [31:0] s_addr, s_wdata, v_addr, v_wdata, mem_rdata;
    logic [3:0]  v_len;
    logic        s_gnt, s_rvalid, v_gnt, v_done, v_rvalid;
    logic [31:0] s_rdata, v_rdata, mem_addr, mem_wdata;
    logic        mem_wr_en, mem_rd_en, busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .s_req     (s_req),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_gnt     (s_gnt),
        .s_rvalid  (s_rvalid),
        .s_rdata   (s_rdata),
        .v_req     (v_req),
        .v_we      (v_we),
        .v_addr    (v_addr),
        .v_len     (v_len),
        .v_wdata   (v_wdata),
        .v_gnt     (v_gnt),
        .v_done    (v_done),
        .v_rvalid  (v_rvalid),
        .v_rdata   (v_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge (inputs are then changed by the caller).
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
        v_req = 1'b0; v_we = 1'b0; v_addr = '0; v_len = '0; v_wdata = '0;
        mem_rdata = '0;

        // Reset state
        tick(); #1;
        chk1("rst_s_gnt", s_gnt, 1'b0);
        chk1("rst_v_gnt", v_gnt, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_s_rvalid", s_rvalid, 1'b0);
        chk32("rst_v_rdata", v_rdata, 32'h0);
        chk1("rst_wr_en", mem_wr_en, 1'b0);

        tick(); rst = 1'b1; #1;
        chk1("idle_rd_en", mem_rd_en, 1'b0);
        chk1("idle_v_done", v_done, 1'b0);

        // Scalar read
        tick(); s_req = 1'b1; s_we = 1'b0; s_addr = 32'h100; mem_rdata = 32'hDEADBEEF; #1;
        chk1("sr_gnt", s_gnt, 1'b1);
        chk1("sr_rd_en", mem_rd_en, 1'b1);
        chk1("sr_wr_en", mem_wr_en, 1'b0);
        chk32("sr_addr", mem_addr, 32'h100);
        chk1("sr_rvalid_early", s_rvalid, 1'b0);
        tick(); s_req = 1'b0; mem_rdata = 32'h12345678; #1;
        chk1("sr_rvalid", s_rvalid, 1'b1);
        chk32("sr_rdata", s_rdata, 32'hDEADBEEF);
        chk1("sr_gnt_off", s_gnt, 1'b0);
        tick(); #1;
        chk1("sr_rvalid_drop", s_rvalid, 1'b0);
        chk32("sr_rdata_hold", s_rdata, 32'hDEADBEEF);

        // Vector write burst of 4; inputs scrambled after beat 0
        tick(); v_req = 1'b1; v_we = 1'b1; v_addr = 32'h200; v_len = 4'd3; v_wdata = 32'hA0; #1;
        chk1("vw0_gnt", v_gnt, 1'b1);
        chk1("vw0_wr", mem_wr_en, 1'b1);
        chk32("vw0_addr", mem_addr, 32'h200);
        chk32("vw0_wdata", mem_wdata, 32'hA0);
        chk1("vw0_busy", busy, 1'b0);
        chk1("vw0_done", v_done, 1'b0);
        tick(); v_req = 1'b0; v_we = 1'b0; v_addr = 32'h9990; v_len = 4'd0; v_wdata = 32'hA1; #1;
        chk32("vw1_addr", mem_addr, 32'h204);
        chk32("vw1_wdata", mem_wdata, 32'hA1);
        chk1("vw1_wr", mem_wr_en, 1'b1);
        chk1("vw1_rd", mem_rd_en, 1'b0);
        chk1("vw1_busy", busy, 1'b1);
        chk1("vw1_rvalid", v_rvalid, 1'b0);
        tick(); v_wdata = 32'hA2; #1;
        chk32("vw2_addr", mem_addr, 32'h208);
        chk1("vw2_done", v_done, 1'b0);
        tick(); v_wdata = 32'hA3; #1;
        chk32("vw3_addr", mem_addr, 32'h20C);
        chk1("vw3_done", v_done, 1'b1);
        chk1("vw3_busy", busy, 1'b1);
        tick(); #1;
        chk1("vw_end_busy", busy, 1'b0);
        chk1("vw_end_gnt", v_gnt, 1'b0);
        chk1("vw_end_wr", mem_wr_en, 1'b0);

        // Conflict right after a reset pulse: scalar first, then vector
        tick(); rst = 1'b0; #1;
        tick(); rst = 1'b1;
        s_req = 1'b1; s_we = 1'b1; s_addr = 32'h40; s_wdata = 32'h55;
        v_req = 1'b1; v_we = 1'b0; v_addr = 32'h300; v_len = 4'd1; #1;
        chk1("cf0_s_gnt", s_gnt, 1'b1);
        chk1("cf0_v_gnt", v_gnt, 1'b0);
        chk32("cf0_addr", mem_addr, 32'h40);
        chk1("cf0_wr", mem_wr_en, 1'b1);
        tick(); mem_rdata = 32'h11111111; #1;
        chk1("cf1_s_gnt", s_gnt, 1'b0);
        chk1("cf1_v_gnt", v_gnt, 1'b1);
        chk32("cf1_addr", mem_addr, 32'h300);
        chk1("cf1_rd", mem_rd_en, 1'b1);
        tick(); mem_rdata = 32'h22222222; v_req = 1'b0; #1;
        chk1("cf2_s_stall", s_gnt, 1'b0);
        chk32("cf2_addr", mem_addr, 32'h304);
        chk1("cf2_done", v_done, 1'b1);
        chk1("cf2_v_rvalid", v_rvalid, 1'b1);
        chk32("cf2_v_rdata", v_rdata, 32'h11111111);
        tick(); #1;
        chk1("cf3_s_gnt", s_gnt, 1'b1);
        chk32("cf3_v_rdata", v_rdata, 32'h22222222);
        tick(); s_req = 1'b0; #1;

        // Address wrap
        tick(); v_req = 1'b1; v_we = 1'b1; v_addr = 32'hFFFFFFFC; v_len = 4'd1; #1;
        chk32("wr0_addr", mem_addr, 32'hFFFFFFFC);
        tick(); v_req = 1'b0; #1;
        chk32("wr1_addr", mem_addr, 32'h00000000);
        chk1("wr1_done", v_done, 1'b1);

        // Single-beat burst: done with beat 0, never busy
        tick(); v_req = 1'b1; v_we = 1'b0; v_addr = 32'h500; v_len = 4'd0; mem_rdata = 32'hCAFE0001; #1;
        chk1("sb_gnt", v_gnt, 1'b1);
        chk1("sb_done", v_done, 1'b1);
        tick(); v_req = 1'b0; #1;
        chk1("sb_busy", busy, 1'b0);
        chk1("sb_rvalid", v_rvalid, 1'b1);
        chk32("sb_rdata", v_rdata, 32'hCAFE0001);

        // Reset in the middle of a 16-beat read
        tick(); v_req = 1'b1; v_we = 1'b0; v_addr = 32'h400; v_len = 4'd15; mem_rdata = 32'h77; #1;
        tick(); v_req = 1'b0; #1;
        tick(); #1;
        chk32("mr2_addr", mem_addr, 32'h408);
        chk1("mr2_gnt", v_gnt, 1'b1);
        rst = 1'b0; #1;
        chk1("mr_rst_gnt", v_gnt, 1'b0);
        chk1("mr_rst_done", v_done, 1'b0);
        chk1("mr_rst_busy", busy, 1'b0);
        chk1("mr_rst_rvalid", v_rvalid, 1'b0);
        chk32("mr_rst_rdata", v_rdata, 32'h0);
        chk1("mr_rst_rd", mem_rd_en, 1'b0);
        tick(); rst = 1'b1; s_req = 1'b1; s_we = 1'b0; s_addr = 32'h80; #1;
        chk1("mr_post_s_gnt", s_gnt, 1'b1);
        chk1("mr_post_v_gnt", v_gnt, 1'b0);
        chk32("mr_post_addr", mem_addr, 32'h80);
        tick(); s_req = 1'b0; #1;
        chk1("mr_post_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
